ip_megarom_ex: RTL

Parametrised MegaROM mapper for the MSX-50BUS cartridge side. It extends the fixed 22-bit mapper with a configurable RAM address width, base offset and bank mask, and adds a persistent SCC-I mode register. RAM accesses go through a busy/rdata_en handshake FSM with a read timeout. It sits between the bus decoder and the SDRAM/PSRAM arbiter port.

---
 rtl/ip_megarom_ex_if.sv | 24 ++
 rtl/ip_megarom_ex.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ip_megarom_ex_if.sv
// Z80 cartridge-side bus between the slot decoder (master) and the MegaROM mapper (slave).
interface ip_megarom_ex_if;
  logic [15:0] bus_address;
  logic        bus_io_cs;
  logic        bus_memory_cs;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;
  logic [7:0]  bus_write_data;
  logic        bus_read;
  logic        bus_write;
  logic        bus_io;
  logic        bus_memory;
  logic        scc_cs;

  modport master (
    output bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory,
    input  bus_io_cs, bus_memory_cs, bus_read_ready, bus_read_data, scc_cs
  );

  modport slave (
    input  bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory,
    output bus_io_cs, bus_memory_cs, bus_read_ready, bus_read_data, scc_cs
  );
endinterface

// File: rtl/ip_megarom_ex.sv
// Parametrised MegaROM mapper: bank registers, SCC/SCC-I windows, SCC+ mode register
// and a request/wait FSM towards the shared RAM port with a read timeout.
module ip_megarom_ex #(
  parameter int                ADDR_W    = 22,
  parameter int                BANK_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 64
) (
  input  logic              n_reset,
  input  logic              clk,
  input  logic [2:0]        mode,
  input  logic [BANK_W-1:0] bank_mask,
  ip_megarom_ex_if.slave    bus,
  output logic              rd,
  output logic              wr,
  input  logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        wdata,
  input  logic [7:0]        rdata,
  input  logic              rdata_en
);

  localparam logic [2:0] MODE_ASC8  = 3'd0;
  localparam logic [2:0] MODE_ASC16 = 3'd1;
  localparam logic [2:0] MODE_KON4  = 3'd3;
  localparam logic [2:0] MODE_SCC   = 3'd4;
  localparam logic [2:0] MODE_SCCP  = 3'd5;
  localparam logic [2:0] MODE_GEN8  = 3'd6;
  localparam logic [2:0] MODE_GEN16 = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t            state_reg;
  logic              rd_reg;
  logic              wr_reg;
  logic              ready_reg;
  logic [7:0]        read_data_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [7:0]        wdata_reg;
  logic [7:0]        count_reg;
  logic              sccp_en_reg;
  logic              sccp_ram_en_reg;

  logic [15:0]       a;
  logic [7:0]        d;
  logic              in_rom;
  logic [1:0]        sel;
  logic              reg_wr;
  logic              is_mode_reg;
  logic              mode_reg_wr;
  logic [3:0]        bank_we;
  logic              pair_wr;
  logic [BANK_W-1:0] bank [4];
  logic [BANK_W-1:0] bank_sel;
  logic [ADDR_W-1:0] ram_addr;
  logic              scc_win;
  logic              scci_win;
  logic              scc_hit;
  logic              rd_accept;
  logic              wr_accept;

  assign a           = bus.bus_address;
  assign d           = bus.bus_write_data;
  assign in_rom      = a[15] ^ a[14];
  // 8K window index: 4000h->0, 6000h->1, 8000h->2, A000h->3
  assign sel         = a[14:13] ^ 2'b10;
  assign reg_wr      = bus.bus_memory & bus.bus_write;
  assign is_mode_reg = (a[15:1] == 15'h5FFF);
  assign mode_reg_wr = reg_wr & is_mode_reg;

  always_comb begin
    bank_we = 4'b0000;
    pair_wr = 1'b0;
    if (reg_wr && !sccp_ram_en_reg) begin
      case (mode)
        MODE_ASC8: begin
          if (a[15:13] == 3'b011) bank_we[a[12:11]] = 1'b1;
        end
        MODE_ASC16: begin
          pair_wr = 1'b1;
          if (a[15:13] == 3'b011 && !a[11]) bank_we = a[12] ? 4'b1100 : 4'b0011;
        end
        MODE_KON4: begin
          if (in_rom && sel != 2'd0) bank_we[sel] = 1'b1;
        end
        MODE_SCC, MODE_SCCP: begin
          if (in_rom && a[12:11] == 2'b10) bank_we[sel] = 1'b1;
        end
        MODE_GEN8: begin
          if (in_rom && !a[11]) bank_we[sel] = 1'b1;
        end
        MODE_GEN16: begin
          pair_wr = 1'b1;
          if (in_rom && !a[11]) bank_we = a[15] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  // Paired modes store a 16K page number as two consecutive 8K banks.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [BANK_W-1:0] value_reg;
    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)
        value_reg <= BANK_W'(gi);
      else if (bank_we[gi])
        value_reg <= pair_wr ? BANK_W'({d[6:0], ((gi % 2) == 1) ? 1'b1 : 1'b0}) : BANK_W'(d);
    end
    assign bank[gi] = value_reg;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sccp_en_reg     <= 1'b0;
      sccp_ram_en_reg <= 1'b0;
    end else if (mode != MODE_SCCP) begin
      sccp_en_reg     <= 1'b0;
      sccp_ram_en_reg <= 1'b0;
    end else begin
      sccp_en_reg     <= mode_reg_wr ? d[5] : sccp_en_reg;
      sccp_ram_en_reg <= mode_reg_wr ? d[4] : sccp_ram_en_reg;
    end
  end

  assign scc_win  = (mode == MODE_SCC || mode == MODE_SCCP) &&
                    (bank[2][5:0] == 6'h3F) && (a[15:11] == 5'b10011);
  assign scci_win = (mode == MODE_SCCP) && bank[3][7] &&
                    (a[15:11] == 5'b10111) && !is_mode_reg;
  assign scc_hit  = scc_win | scci_win;

  assign bank_sel = bank[sel];
  assign ram_addr = BASE_ADDR + ADDR_W'({bank_sel & bank_mask, a[12:0]});

  assign rd_accept = (state_reg == ST_IDLE) && bus.bus_memory && bus.bus_read &&
                     in_rom && !scc_hit;
  assign wr_accept = (state_reg == ST_IDLE) && reg_wr && !bus.bus_read &&
                     (mode == MODE_SCCP) && sccp_ram_en_reg && in_rom &&
                     !scc_hit && !is_mode_reg;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg     <= ST_IDLE;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      ready_reg     <= 1'b0;
      read_data_reg <= 8'h00;
      address_reg   <= BASE_ADDR;
      wdata_reg     <= 8'h00;
      count_reg     <= 8'd0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (rd_accept || wr_accept) begin
            address_reg <= ram_addr;
            wdata_reg   <= d;
            rd_reg      <= rd_accept;
            wr_reg      <= wr_accept;
            state_reg   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!busy) begin
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            count_reg <= 8'd0;
            state_reg <= rd_reg ? ST_WAIT : ST_IDLE;
          end
        end
        ST_WAIT: begin
          // Real data takes priority over a timeout landing on the same edge.
          if (rdata_en) begin
            read_data_reg <= rdata;
            ready_reg     <= 1'b1;
            state_reg     <= ST_IDLE;
          end else if (count_reg == 8'(TIMEOUT - 1)) begin
            read_data_reg <= 8'hFF;
            ready_reg     <= 1'b1;
            state_reg     <= ST_IDLE;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.bus_io_cs      = 1'b0;
  assign bus.bus_memory_cs  = in_rom;
  assign bus.bus_read_ready = ready_reg;
  assign bus.bus_read_data  = read_data_reg;
  assign bus.scc_cs         = scc_hit;
  assign rd                 = rd_reg;
  assign wr                 = wr_reg;
  assign address            = address_reg;
  assign wdata              = wdata_reg;

endmodule
